// File: rtl/iencode_pkg.sv
// Shared encodings for the RV32I instruction encoder/loader.
// Opcodes, funct3 values, request op codes and error codes.
package iencode_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_ANDI = 3'b111;

   typedef enum logic [1:0] {
      OP_LUI  = 2'd0,
      OP_ADDI = 2'd1,
      OP_ANDI = 2'd2,
      OP_LI   = 2'd3
   } req_op_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_IMM   = 2'd1,
      ERR_SPACE = 2'd2,
      ERR_OP    = 2'd3
   } err_code_t;

   // True when v is the sign extension of its low 12 bits (-2048..2047).
   function automatic logic fits_simm12(input logic [31:0] v);
      return (v[31:11] == {21{v[11]}});
   endfunction

endpackage

// File: rtl/iencode_word.sv
// Combinational packer: turns (op, rd, rs1, imm) into one RV32I word.
// Only LUI, ADDI and ANDI are encoded; any other op falls back to ADDI.
module iencode_word
   import iencode_pkg::*;
(
   input  req_op_t     op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [31:0] imm,
   output logic [31:0] word
);

   always_comb begin
      word = '0;
      case (op)
         OP_LUI:  word = {imm[31:12], rd, OPC_LUI};
         OP_ANDI: word = {imm[11:0], rs1, F3_ANDI, rd, OPC_OP_IMM};
         default: word = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
      endcase
   end

endmodule

// File: rtl/iencode_loader.sv
// Accepts LUI/ADDI/ANDI/LI requests, encodes them and streams words into instruction memory.
// Define IENCODE_LI_EN to build the LI pseudo-op (single word or LUI+ADDI pair via EMIT2).
module iencode_loader
   import iencode_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [31:0]       req_imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              full,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);

   state_t      state;
   logic [ADDR_W:0] wc_inc;
   req_op_t     enc_op;
   logic [4:0]  enc_rd;
   logic [4:0]  enc_rs1;
   logic [31:0] enc_imm;
   logic [31:0] enc_word;
   err_code_t   chk_code;
   logic        req_fits;

`ifdef IENCODE_LI_EN
   localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
   logic        two_word;
   logic        no_room;
   logic        pending_reg;
   logic [4:0]  rd_reg;
   logic [11:0] lo_reg;

   assign no_room = ({1'b0, word_count} + (ADDR_W+2)'(2)) > DEPTH_X;
`endif

   assign wc_inc   = word_count + CNT_ONE;
   assign req_fits = fits_simm12(req_imm);

   // One encoder serves both the accepted request and the pending ADDI half of an LI.
   always_comb begin
      enc_op  = req_op_t'(req_op);
      enc_rd  = req_rd;
      enc_rs1 = req_rs1;
      enc_imm = req_imm;
`ifdef IENCODE_LI_EN
      two_word = 1'b0;
      if (state == EMIT1) begin
         enc_op  = OP_ADDI;
         enc_rd  = rd_reg;
         enc_rs1 = rd_reg;
         enc_imm = {20'd0, lo_reg};
      end else if (req_op_t'(req_op) == OP_LI) begin
         if (req_fits) begin
            enc_op  = OP_ADDI;
            enc_rs1 = 5'd0;
         end else begin
            enc_op = OP_LUI;
            if (req_imm[11:0] != 12'd0) begin
               // Rounding the upper part compensates for the sign-extended low half.
               enc_imm  = req_imm + 32'h0000_0800;
               two_word = 1'b1;
            end
         end
      end
`endif
   end

   always_comb begin
      chk_code = ERR_NONE;
      case (req_op_t'(req_op))
         OP_LUI:           if (req_imm[11:0] != 12'd0) chk_code = ERR_IMM;
         OP_ADDI, OP_ANDI: if (!req_fits) chk_code = ERR_IMM;
         default: begin
`ifdef IENCODE_LI_EN
            if (two_word && no_room) chk_code = ERR_SPACE;
`else
            chk_code = ERR_OP;
`endif
         end
      endcase
   end

   iencode_word u_word (
      .op   (enc_op),
      .rd   (enc_rd),
      .rs1  (enc_rs1),
      .imm  (enc_imm),
      .word (enc_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
         full       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
`ifdef IENCODE_LI_EN
         pending_reg <= 1'b0;
         rd_reg      <= '0;
         lo_reg      <= '0;
`endif
      end else begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
         case (state)
            IDLE: begin
               req_ready <= !full;
               if (req_valid && req_ready) begin
                  if (chk_code != ERR_NONE) begin
                     err      <= 1'b1;
                     err_code <= chk_code;
                  end else begin
                     mem_we    <= 1'b1;
                     mem_wdata <= enc_word;
                     req_ready <= 1'b0;
                     state     <= EMIT1;
`ifdef IENCODE_LI_EN
                     pending_reg <= two_word;
                     rd_reg      <= req_rd;
                     lo_reg      <= req_imm[11:0];
`endif
                  end
               end
            end
            EMIT1: begin
               if (mem_ready) begin
                  word_count <= wc_inc;
                  full       <= (wc_inc == CNT_DEPTH);
                  // Hold the address rather than wrap once the last word index is used.
                  if (!wc_inc[ADDR_W]) mem_addr <= wc_inc[ADDR_W-1:0];
`ifdef IENCODE_LI_EN
                  if (pending_reg) begin
                     mem_wdata   <= enc_word;
                     pending_reg <= 1'b0;
                     state       <= EMIT2;
                  end else
`endif
                  begin
                     mem_we    <= 1'b0;
                     req_ready <= (wc_inc != CNT_DEPTH);
                     state     <= IDLE;
                  end
               end
            end
`ifdef IENCODE_LI_EN
            EMIT2: begin
               if (mem_ready) begin
                  word_count <= wc_inc;
                  full       <= (wc_inc == CNT_DEPTH);
                  if (!wc_inc[ADDR_W]) mem_addr <= wc_inc[ADDR_W-1:0];
                  mem_we    <= 1'b0;
                  req_ready <= (wc_inc != CNT_DEPTH);
                  state     <= IDLE;
               end
            end
`endif
            default: begin
               mem_we <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/iencode_loader.md
Name: iencode_loader

Overview:
Encoder counterpart of the instruction decoder. Accepts LUI/ADDI/ANDI/LI requests, packs them into RV32I instruction words and writes them sequentially into instruction memory through a handshaked write port. Sits between the test/boot program source and the instruction RAM that feeds the fetch/decode path.

Parameters:
ADDR_W, 8, width of mem_addr (word index).
DEPTH, 256, number of writable words; must be 1 to 2**ADDR_W.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  2  0=LUI, 1=ADDI, 2=ANDI, 3=LI (pseudo)
req_rd  in  5  destination register
req_rs1  in  5  source register (ADDI/ANDI only)
req_imm  in  32  immediate, full 32-bit value
mem_we  out  1  write request to instruction memory
mem_ready  in  1  memory accepts write this cycle
mem_addr  out  ADDR_W  word index of write
mem_wdata  out  32  encoded instruction
word_count  out  ADDR_W+1  words written since reset
full  out  1  word_count == DEPTH
err  out  1  one-cycle pulse: request rejected
err_code  out  2  valid with err: 1=imm range, 2=no space, 3=op disabled

Behaviour:
- Reset values: req_ready 0 during reset, then 1; mem_we 0; mem_addr 0; mem_wdata 0; word_count 0; full 0; err 0; err_code 0; state IDLE.
- States: IDLE, EMIT1, EMIT2.
- req_ready = (state==IDLE) && !full. Accept = req_valid && req_ready; fields are latched.
- Encoding: LUI = imm[31:12]|rd|0110111. OP_IMM = imm[11:0]|rs1|funct3|rd|0010011; funct3 is 000 for ADDI and 111 for ANDI.
- Checks at accept, in priority order: op check, then imm check, then space check.
  - LUI requires req_imm[11:0]==0.
  - ADDI/ANDI require req_imm to be a sign-extended 12-bit value (-2048..2047).
  - LI accepts any value.
- Rejected request: err=1 with err_code on the cycle after accept, no write, state stays IDLE.
- LI expansion:
  - imm in -2048..2047: single word, ADDI rd,x0,imm.
  - else if imm[11:0]==0: single word, LUI rd,imm.
  - else two words: LUI rd,hi then ADDI rd,rd,lo. lo = imm[11:0] sign-extended; hi = (imm + 32'h800)[31:12], with wrap-around modulo 2^32.
- A two-word LI with DEPTH-word_count < 2 is rejected with err_code 2. No partial write occurs.
- Latency: accept at cycle N gives mem_we=1 with valid mem_addr/mem_wdata at N+1 (state EMIT1). All outputs are registered.
- Backpressure: while mem_we && !mem_ready, mem_we, mem_addr and mem_wdata are held stable.
- On mem_we && mem_ready:
  - mem_addr and word_count increment.
  - Go to EMIT2 if a second LI word is pending, else go to IDLE.
  - EMIT2 behaves like EMIT1 with the ADDI word.
  - mem_we drops on the cycle after the last write completes.
- full is asserted when word_count reaches DEPTH and stays asserted until reset. There is no wrap of mem_addr.
- Reset mid-operation aborts the write immediately and returns to IDLE. Words already written remain in memory, but word_count returns to 0.

Optional Feature:
IENCODE_LI_EN
- Defined: req_op 3 behaves as LI as described above.
- Undefined: EMIT2 and the LI logic are not built. req_op 3 is accepted and rejected with err_code 3, with no write.

Decomposition:
- Package iencode_pkg holds:
  - Opcode constants: LUI 7'b0110111, OP_IMM 7'b0010011.
  - funct3 constants: ADDI 3'b000, ANDI 3'b111.
  - req_op encodings and err_code encodings.
- One combinational sub-module, iencode_word, packs (op, rd, rs1, imm) into a 32-bit word. The FSM, counter and LI split stay in iencode_loader.

Test Plan:
- ADDI rd=1 rs1=0 imm=5 -> one write at addr 0, mem_wdata 32'h00500093, word_count 1.
- ANDI rd=2 rs1=1 imm=-1 -> mem_wdata 32'hFFF0F113. LUI rd=3 imm=32'h12345000 -> mem_wdata 32'h123451B7.
- LI rd=5 imm=32'h12345FFF -> two consecutive writes, 32'h123462B7 then 32'hFFF28293; req_ready low until the second write completes.
- ADDI imm=2048 -> err=1 with err_code 1, no mem_we. LUI imm=32'h00000001 -> err_code 1.
- mem_ready held low for 3 cycles during a write -> mem_we/addr/wdata stable; write completes on the 4th cycle.
- DEPTH=4: three single-word writes, then a two-word LI -> err_code 2. A fourth single write -> full=1, req_ready=0. Reset -> word_count 0, addr 0.
